// File: rtl/ac_motor_deadtime_monitor.sv
// Receive-side checker for a complementary gate pair. It rebuilds the
// commanded bridge state from s_high/s_low, times every dead-time gap in
// clock cycles and raises sticky faults on shoot-through or short dead time.
module ac_motor_deadtime_monitor #(
    parameter int DELAY_W = 11,
    parameter int SAT_MAX = 2**DELAY_W-1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [DELAY_W-1:0] min_delay,
    input  logic               s_high,
    input  logic               s_low,
    input  logic               clear_fault,
    output logic               s_rec,
    output logic [DELAY_W-1:0] dt_meas,
    output logic               dt_valid,
    output logic               fault_shoot,
    output logic               fault_short_dt
);

    localparam logic [DELAY_W-1:0] CNT_SAT = DELAY_W'(SAT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        HIGH_ON,
        LOW_ON,
        DEAD_H,
        DEAD_L,
        SHOOT
    } state_t;

    state_t             state;
    logic               hq;
    logic               lq;
    logic [DELAY_W-1:0] counter;

    // Single register stage on the gate inputs; the FSM only looks at hq/lq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hq <= 1'b0;
            lq <= 1'b0;
        end else begin
            hq <= s_high;
            lq <= s_low;
        end
    end

    // Bridge-state FSM with dead-time counter and all registered outputs.
    // Fault clear is applied first so a same-cycle fault set overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            counter        <= '0;
            s_rec          <= 1'b0;
            dt_meas        <= '0;
            dt_valid       <= 1'b0;
            fault_shoot    <= 1'b0;
            fault_short_dt <= 1'b0;
        end else begin
            dt_valid <= 1'b0;
            if (clear_fault) begin
                fault_shoot    <= 1'b0;
                fault_short_dt <= 1'b0;
            end

            if (!enable) begin
                state   <= IDLE;
                counter <= '0;
                s_rec   <= 1'b0;
            end else if (hq && lq) begin
                // Shoot-through from any state; s_rec holds, nothing measured.
                state       <= SHOOT;
                counter     <= '0;
                fault_shoot <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Entry from idle never yields a measurement.
                        if (hq) begin
                            state <= HIGH_ON;
                            s_rec <= 1'b1;
                        end else if (lq) begin
                            state <= LOW_ON;
                            s_rec <= 1'b0;
                        end
                    end
                    HIGH_ON: begin
                        if (lq) begin
                            // Hard commutation: zero dead cycles.
                            state    <= LOW_ON;
                            s_rec    <= 1'b0;
                            dt_meas  <= '0;
                            dt_valid <= 1'b1;
                            if (min_delay != '0) fault_short_dt <= 1'b1;
                        end else if (!hq) begin
                            state   <= DEAD_H;
                            counter <= DELAY_W'(1);
                        end
                    end
                    LOW_ON: begin
                        if (hq) begin
                            state    <= HIGH_ON;
                            s_rec    <= 1'b1;
                            dt_meas  <= '0;
                            dt_valid <= 1'b1;
                            if (min_delay != '0) fault_short_dt <= 1'b1;
                        end else if (!lq) begin
                            state   <= DEAD_L;
                            counter <= DELAY_W'(1);
                        end
                    end
                    DEAD_H: begin
                        if (lq) begin
                            state    <= LOW_ON;
                            s_rec    <= 1'b0;
                            counter  <= '0;
                            dt_meas  <= counter;
                            dt_valid <= 1'b1;
                            if (counter < min_delay) fault_short_dt <= 1'b1;
                        end else if (hq) begin
                            // Same side came back: a glitch, not a commutation.
                            state   <= HIGH_ON;
                            s_rec   <= 1'b1;
                            counter <= '0;
                        end else if (counter != CNT_SAT) begin
                            counter <= counter + 1'b1;
                        end
                    end
                    DEAD_L: begin
                        if (hq) begin
                            state    <= HIGH_ON;
                            s_rec    <= 1'b1;
                            counter  <= '0;
                            dt_meas  <= counter;
                            dt_valid <= 1'b1;
                            if (counter < min_delay) fault_short_dt <= 1'b1;
                        end else if (lq) begin
                            state   <= LOW_ON;
                            s_rec   <= 1'b0;
                            counter <= '0;
                        end else if (counter != CNT_SAT) begin
                            counter <= counter + 1'b1;
                        end
                    end
                    SHOOT: begin
                        // Leaving shoot-through never starts a dead-time measurement.
                        if (hq) begin
                            state <= HIGH_ON;
                            s_rec <= 1'b1;
                        end else if (lq) begin
                            state <= LOW_ON;
                            s_rec <= 1'b0;
                        end else begin
                            state <= IDLE;
                            s_rec <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        counter <= '0;
                        s_rec   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ac_motor_deadtime_monitor.sv
// Bench for ac_motor_deadtime_monitor: directed segment table, a latency
// sequence, then random segments checked every cycle against a gap-length
// reference model.
module tb_ac_motor_deadtime_monitor;

    localparam int DW  = 11;
    localparam int SAT = 2**DW - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] min_delay = '0;
    logic          s_high = 1'b0;
    logic          s_low = 1'b0;
    logic          clear_fault = 1'b0;
    logic          s_rec;
    logic [DW-1:0] dt_meas;
    logic          dt_valid;
    logic          fault_shoot;
    logic          fault_short_dt;

    int total = 0;
    int bad = 0;
    int model_prints = 0;

    ac_motor_deadtime_monitor #(.DELAY_W(DW), .SAT_MAX(SAT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .min_delay(min_delay),
        .s_high(s_high), .s_low(s_low), .clear_fault(clear_fault),
        .s_rec(s_rec), .dt_meas(dt_meas), .dt_valid(dt_valid),
        .fault_shoot(fault_shoot), .fault_short_dt(fault_short_dt)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the last conducting side and how many
    // both-off samples have followed it; a commutation reports that gap.
    int            m_side = 0;   // 0 none, 1 high, 2 low
    int            m_gap = 0;
    logic          m_hq = 0, m_lq = 0;
    logic          m_rec = 0, m_val = 0, m_fs = 0, m_fdt = 0;
    logic [DW-1:0] m_meas = '0;

    task automatic model_step();
        if (!rst_n) begin
            m_side = 0; m_gap = 0; m_hq = 0; m_lq = 0;
            m_rec = 0; m_val = 0; m_fs = 0; m_fdt = 0; m_meas = '0;
        end else begin
            m_val = 0;
            if (clear_fault) begin m_fs = 0; m_fdt = 0; end
            if (!enable) begin
                m_side = 0; m_gap = 0; m_rec = 0;
            end else if (m_hq && m_lq) begin
                m_fs = 1; m_side = 0; m_gap = 0;
            end else if (m_hq || m_lq) begin
                int side;
                int d;
                side = m_hq ? 1 : 2;
                if (m_side != 0 && m_side != side) begin
                    d = (m_gap > SAT) ? SAT : m_gap;
                    m_meas = DW'(d);
                    m_val = 1;
                    if (d < int'(min_delay)) m_fdt = 1;
                end
                m_side = side; m_gap = 0; m_rec = (side == 1);
            end else begin
                if (m_side != 0) m_gap++;
                else m_rec = 0;
            end
            m_hq = s_high; m_lq = s_low;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        total++;
        if ({s_rec, dt_valid, fault_shoot, fault_short_dt, dt_meas} !==
            {m_rec, m_val, m_fs, m_fdt, m_meas}) begin
            bad++;
            if (model_prints < 30)
                $display("FAIL model @%0t: got rec=%b val=%b fs=%b fdt=%b meas=%0d want rec=%b val=%b fs=%b fdt=%b meas=%0d",
                         $time, s_rec, dt_valid, fault_shoot, fault_short_dt, dt_meas,
                         m_rec, m_val, m_fs, m_fdt, m_meas);
            model_prints++;
        end
    endtask

    typedef struct {
        logic rst, en, clr, h, l;
        int   n, md;
        logic rec;
        int   meas, pulses;
        logic fs, fdt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, en, clr, h, l, input int n, md,
                               input logic rec, input int meas, pulses,
                               input logic fs, fdt);
        vec_t t;
        t.rst = rst; t.en = en; t.clr = clr; t.h = h; t.l = l; t.n = n; t.md = md;
        t.rec = rec; t.meas = meas; t.pulses = pulses; t.fs = fs; t.fdt = fdt;
        return t;
    endfunction

    initial begin
        // rst en clr h l  n  md  rec meas p fs fdt
        tbl.push_back(v(0,1,0,0,1,  50,10, 0,   0,0,0,0)); // idle -> low, no measurement
        tbl.push_back(v(0,1,0,0,0,  15,10, 0,   0,0,0,0));
        tbl.push_back(v(0,1,0,1,0,  30,10, 1,  15,1,0,0)); // nominal 15
        tbl.push_back(v(0,1,0,0,0,  20,10, 1,  15,0,0,0));
        tbl.push_back(v(0,1,0,0,1,  30,10, 0,  20,1,0,0)); // reverse 20
        tbl.push_back(v(0,1,0,0,0,   4,10, 0,  20,0,0,0));
        tbl.push_back(v(0,1,0,1,0,  10,10, 1,   4,1,0,1)); // short 4
        tbl.push_back(v(0,1,0,0,0,   4,10, 1,   4,0,0,1));
        tbl.push_back(v(0,1,0,0,1,  10,10, 0,   4,1,0,1)); // short, sticky
        tbl.push_back(v(0,1,1,0,1,   5,10, 0,   4,0,0,0)); // clear
        tbl.push_back(v(0,1,0,1,0,   5,10, 1,   0,1,0,1)); // direct, zero dead
        tbl.push_back(v(0,1,1,1,0,   3,10, 1,   0,0,0,0));
        tbl.push_back(v(0,1,0,0,1,   5, 0, 0,   0,1,0,0)); // direct, min 0
        tbl.push_back(v(0,1,0,0,0,  10,10, 0,   0,0,0,0));
        tbl.push_back(v(0,1,0,1,0,   5,10, 1,  10,1,0,0)); // equal to min: legal
        tbl.push_back(v(0,1,0,0,0,   9,10, 1,  10,0,0,0));
        tbl.push_back(v(0,1,0,0,1,   5,10, 0,   9,1,0,1)); // min-1: short
        tbl.push_back(v(0,1,1,0,1,   3,10, 0,   9,0,0,0));
        tbl.push_back(v(0,1,0,0,0,  12,10, 0,   9,0,0,0));
        tbl.push_back(v(0,1,0,1,0,   5,10, 1,  12,1,0,0));
        tbl.push_back(v(0,1,0,1,1,   3,10, 1,  12,0,1,0)); // shoot-through
        tbl.push_back(v(0,1,1,1,1,   3,10, 1,  12,0,1,0)); // set beats clear
        tbl.push_back(v(0,1,0,1,0,   5,10, 1,  12,0,1,0)); // shoot -> high, no meas
        tbl.push_back(v(0,1,1,1,0,   3,10, 1,  12,0,0,0));
        tbl.push_back(v(0,1,0,1,1,   3,10, 1,  12,0,1,0));
        tbl.push_back(v(0,1,0,0,0,   5,10, 0,  12,0,1,0)); // shoot -> idle
        tbl.push_back(v(0,1,1,0,1,   5,10, 0,  12,0,0,0)); // idle -> low, no meas
        tbl.push_back(v(0,1,0,0,0,  11,10, 0,  12,0,0,0));
        tbl.push_back(v(0,1,0,1,0,   5,10, 1,  11,1,0,0));
        tbl.push_back(v(0,1,0,0,0,   5,10, 1,  11,0,0,0));
        tbl.push_back(v(0,1,0,1,0,   5,10, 1,  11,0,0,0)); // glitch
        tbl.push_back(v(0,1,0,0,0,3000,10, 1,  11,0,0,0));
        tbl.push_back(v(0,1,0,0,1,   5,10, 0,2047,1,0,0)); // saturated
        tbl.push_back(v(0,1,0,0,0,   5,10, 0,2047,0,0,0));
        tbl.push_back(v(0,0,0,0,0,   3,10, 0,2047,0,0,0)); // disable mid-dead
        tbl.push_back(v(0,1,0,1,0,   5,10, 1,2047,0,0,0)); // re-enable opposite
        tbl.push_back(v(0,1,0,0,0,   5,10, 1,2047,0,0,0));
        tbl.push_back(v(1,1,0,0,0,   2,10, 0,   0,0,0,0)); // reset mid-dead
        tbl.push_back(v(0,1,0,0,1,   5,10, 0,   0,0,0,0));

        // Reset and idle
        rst_n = 1'b0; enable = 1'b1; min_delay = DW'(10);
        repeat (3) tick();
        chk("rst_rec", int'(s_rec), 0);
        chk("rst_meas", int'(dt_meas), 0);
        chk("rst_valid", int'(dt_valid), 0);
        chk("rst_faults", int'({fault_shoot, fault_short_dt}), 0);
        rst_n = 1'b1;
        begin
            int p;
            p = 0;
            repeat (5) begin tick(); p += int'(dt_valid); end
            chk("idle_pulses", p, 0);
            chk("idle_rec", int'(s_rec), 0);
        end

        // Directed segment table
        foreach (tbl[i]) begin
            int p;
            p = 0;
            rst_n = ~tbl[i].rst; enable = tbl[i].en; clear_fault = tbl[i].clr;
            s_high = tbl[i].h; s_low = tbl[i].l; min_delay = DW'(tbl[i].md);
            repeat (tbl[i].n) begin tick(); p += int'(dt_valid); end
            chk($sformatf("v%0d_rec", i), int'(s_rec), int'(tbl[i].rec));
            chk($sformatf("v%0d_meas", i), int'(dt_meas), tbl[i].meas);
            chk($sformatf("v%0d_pulses", i), p, tbl[i].pulses);
            chk($sformatf("v%0d_fshoot", i), int'(fault_shoot), int'(tbl[i].fs));
            chk($sformatf("v%0d_fshort", i), int'(fault_short_dt), int'(tbl[i].fdt));
        end
        rst_n = 1'b1; clear_fault = 1'b0; enable = 1'b1;

        // Two-edge latency and one-cycle pulse width (from LOW_ON, min 10)
        s_high = 1'b0; s_low = 1'b0;
        repeat (6) tick();
        s_high = 1'b1;
        tick();
        chk("lat1_valid", int'(dt_valid), 0);
        chk("lat1_rec", int'(s_rec), 0);
        tick();
        chk("lat2_valid", int'(dt_valid), 1);
        chk("lat2_meas", int'(dt_meas), 6);
        chk("lat2_rec", int'(s_rec), 1);
        chk("lat2_fshort", int'(fault_short_dt), 1);
        tick();
        chk("lat3_valid", int'(dt_valid), 0);
        clear_fault = 1'b1;
        repeat (2) tick();
        clear_fault = 1'b0;

        // Random segments against the model
        for (int seg = 0; seg < 400; seg++) begin
            int r;
            int len;
            r = int'($urandom_range(0, 99));
            if (r < 40)      begin s_high = 1'b1; s_low = 1'b0; end
            else if (r < 80) begin s_high = 1'b0; s_low = 1'b1; end
            else if (r < 95) begin s_high = 1'b0; s_low = 1'b0; end
            else             begin s_high = 1'b1; s_low = 1'b1; end
            len = int'($urandom_range(1, 25));
            if (seg == 200) begin s_high = 1'b0; s_low = 1'b0; len = 2100; end
            min_delay   = DW'($urandom_range(0, 20));
            clear_fault = ($urandom_range(0, 9) == 0);
            enable      = ($urandom_range(0, 19) != 0);
            rst_n       = ($urandom_range(0, 59) != 0);
            repeat (len) tick();
        end
        rst_n = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ac_motor_deadtime_monitor.md
Name: ac_motor_deadtime_monitor

Overview:
- Receive-side checker for the complementary gate pair produced by the AC motor switch-delay stage.
- Observes s_high/s_low and reconstructs the commanded bridge state.
- Measures every dead-time interval in clock cycles.
- Flags shoot-through (both gates on) and dead times shorter than a programmable minimum.
- Sits between the switch-delay block and the gate-driver outputs. Its fault outputs feed the motor enable/trip logic.

Parameters:
- DELAY_W, 11, width of dead-time measurement and min_delay; matches the switch-delay block's delay port.
- SAT_MAX, 2**DELAY_W-1, saturation value of the dead-time counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  monitor enable; 0 forces IDLE.
- min_delay  input  DELAY_W  minimum legal dead time in cycles; sampled whenever a measurement completes.
- s_high  input  1  high-side gate signal, synchronous to clk.
- s_low  input  1  low-side gate signal, synchronous to clk.
- clear_fault  input  1  synchronous clear of both sticky faults.
- s_rec  output  1  reconstructed bridge state (1 = high side conducting).
- dt_meas  output  DELAY_W  last completed dead-time measurement.
- dt_valid  output  1  one-cycle pulse when dt_meas updates.
- fault_shoot  output  1  sticky: both gates seen on simultaneously.
- fault_short_dt  output  1  sticky: a completed dead time was below min_delay.

Behaviour:
- Reset (rst_n=0, async): all outputs 0; input registers 0; counter 0; state IDLE.
- Input stage: s_high/s_low are registered once (hq/lq). The FSM acts on hq/lq. All outputs are registered.
  - Latency: outputs reflect a gate change 2 clk edges after the change is first sampled.
- States: IDLE, HIGH_ON (hq=1,lq=0), LOW_ON (hq=0,lq=1), DEAD_H (both 0, previous side high), DEAD_L (both 0, previous side low), SHOOT (hq=1,lq=1).
- Transitions with enable=1:
  - IDLE->HIGH_ON or LOW_ON on the first one-hot sample. Both low stays in IDLE.
  - HIGH_ON->DEAD_H on both low; LOW_ON->DEAD_L on both low. The counter is loaded with 1 on entry.
  - DEAD_x: counter +1 per cycle both low, saturating at SAT_MAX.
  - DEAD_H->LOW_ON or DEAD_L->HIGH_ON (opposite side turns on) completes a measurement:
    - dt_meas <= counter; dt_valid=1 for exactly one cycle.
    - If counter < min_delay, set fault_short_dt.
  - DEAD_H->HIGH_ON or DEAD_L->LOW_ON (same side returns, a glitch): no measurement, dt_valid stays 0, counter cleared.
  - Direct HIGH_ON<->LOW_ON (zero dead cycles) completes a measurement with dt_meas=0. fault_short_dt is set if min_delay>0.
  - Any state with hq=lq=1: go to SHOOT and set fault_shoot. No measurement is made.
  - SHOOT exits to HIGH_ON/LOW_ON/IDLE per the one-hot or both-low sample. Exit to IDLE occurs when both are low; no dead-time measurement follows.
- s_rec: 1 in HIGH_ON, 0 in LOW_ON. Holds its previous value in DEAD_x and SHOOT. 0 in IDLE.
- enable=0: state IDLE, counter 0, dt_valid 0, s_rec 0. dt_meas and both faults hold.
- Re-enable: first one-hot sample goes IDLE->side state; no measurement on re-enable.
- clear_fault: clears both sticky faults next edge. If a new fault condition occurs in the same cycle, the fault is set (set wins).
- Reset mid-dead-interval: the measurement is discarded. Entry from IDLE never produces dt_valid.

Test Plan:
- Reset and idle: rst_n=0 then 1 with both gates low -> all outputs 0, state IDLE, no dt_valid.
- Nominal, min_delay=10: low-only for 50 cycles, both low 15 cycles, then high-only -> single dt_valid pulse, dt_meas=15, s_rec 0->1, no faults. Reverse direction with 20 dead cycles -> dt_meas=20, s_rec 1->0.
- Short dead time, min_delay=10: high-only, 4 both-low cycles, low-only -> dt_meas=4, fault_short_dt=1 and stays 1. Pulse clear_fault -> 0.
- Shoot-through: from HIGH_ON, drive s_low=1 for 3 cycles -> fault_shoot=1, no dt_valid. Assert clear_fault in a cycle with both high -> fault_shoot remains 1.
- Glitch and saturation:
  - high-only, 5 both-low, high-only -> no dt_valid.
  - both low for 3000 cycles then opposite side -> dt_meas=2047.
- Enable/reset mid-operation: drop enable during a dead interval, re-enable on opposite side -> no dt_valid, dt_meas unchanged. Repeat with an rst_n pulse -> dt_meas=0.
